// File: rtl/collision_arbiter_if.sv
// Bundle of the frame-boundary, collision and grant signals that the
// collision arbiter exchanges with the game logic around it.
interface collision_arbiter_if;
  logic       startOfFrame;
  logic       pause;
  logic       collisionBallBottom;
  logic       collisionBallFlipper;
  logic       collisionBallSpring;
  logic       collisionBallBumper;
  logic       collisionBallObstacle;
  logic       collisionBallCredit;
  logic       collisionBallFrame;
  logic       eventValid;
  logic [2:0] eventId;
  logic [6:0] eventOneHot;
  logic [7:0] dropCount;

  // Game side: drives frame timing and collision pulses, consumes grants.
  modport master (
    output startOfFrame, pause,
    output collisionBallBottom, collisionBallFlipper, collisionBallSpring,
    output collisionBallBumper, collisionBallObstacle, collisionBallCredit,
    output collisionBallFrame,
    input  eventValid, eventId, eventOneHot, dropCount
  );

  // Arbiter side.
  modport slave (
    input  startOfFrame, pause,
    input  collisionBallBottom, collisionBallFlipper, collisionBallSpring,
    input  collisionBallBumper, collisionBallObstacle, collisionBallCredit,
    input  collisionBallFrame,
    output eventValid, eventId, eventOneHot, dropCount
  );
endinterface

// File: rtl/collision_arbiter.sv
// Per-frame collision arbiter. Collision pulses are latched into sticky
// pending flags during a frame; at each startOfFrame the highest-priority
// pending source that is not cooling down is granted. Granted sources are
// masked for COOLDOWN_FRAMES evaluations, a BOTTOM grant clears every
// cooldown, and frames where more than one source was eligible are counted.
module collision_arbiter #(
  parameter int unsigned COOLDOWN_FRAMES = 4
) (
  input  logic          clk,
  input  logic          reset,
  collision_arbiter_if.slave bus
);

  localparam logic [2:0] COOL_LOAD = 3'(COOLDOWN_FRAMES);
  localparam logic [2:0] ID_BOTTOM = 3'd1;

  // Bit i of each vector belongs to source ID i+1 (bit 0 = BOTTOM).
  logic [6:0] collisions;
  logic [6:0] eligible;
  logic [2:0] winnerId;
  logic       multiEligible;

  logic [6:0] pendingQ, pendingD;
  logic [2:0] coolQ [7];
  logic [2:0] coolD [7];
  logic       eventValidQ, eventValidD;
  logic [2:0] eventIdQ, eventIdD;
  logic [6:0] eventOneHotQ, eventOneHotD;
  logic [7:0] dropCountQ, dropCountD;

  assign collisions = {bus.collisionBallFrame,    bus.collisionBallCredit,
                       bus.collisionBallObstacle, bus.collisionBallBumper,
                       bus.collisionBallSpring,   bus.collisionBallFlipper,
                       bus.collisionBallBottom};

  // Eligibility and fixed-priority winner, from pre-update pending/cooldown state.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 7; i++) begin
      eligible[i] = pendingQ[i] && (coolQ[i] == 3'd0);
    end
    winnerId = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (eligible[i]) winnerId = 3'(i + 1);
    end
    // More than one bit set <=> clearing the lowest set bit leaves something.
    multiEligible = |(eligible & (eligible - 7'd1));
  end

  // Next-state: capture during the frame, evaluate and reload at the boundary.
  always_comb begin
    pendingD     = pendingQ;
    coolD        = coolQ;
    eventValidD  = 1'b0;
    eventIdD     = eventIdQ;
    eventOneHotD = eventOneHotQ;
    dropCountD   = dropCountQ;
    if (bus.startOfFrame) begin
      if (bus.pause) begin
        pendingD     = '0;
        eventIdD     = 3'd0;
        eventOneHotD = '0;
      end else begin
        // Collisions on the boundary cycle belong to the frame just starting.
        pendingD     = collisions;
        eventValidD  = (winnerId != 3'd0);
        eventIdD     = winnerId;
        eventOneHotD = '0;
        for (int i = 0; i < 7; i++) begin
          if (winnerId == 3'(i + 1)) eventOneHotD[i] = 1'b1;
        end
        if (multiEligible && (dropCountQ != 8'hFF)) begin
          dropCountD = dropCountQ + 8'd1;
        end
        for (int i = 0; i < 7; i++) begin
          if (winnerId == ID_BOTTOM) begin
            coolD[i] = 3'd0;
          end else if (winnerId == 3'(i + 1)) begin
            coolD[i] = COOL_LOAD;
          end else if (coolQ[i] != 3'd0) begin
            coolD[i] = coolQ[i] - 3'd1;
          end
        end
      end
    end else if (!bus.pause) begin
      pendingD = pendingQ | collisions;
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      pendingQ     <= '0;
      coolQ        <= '{default: 3'd0};
      eventValidQ  <= 1'b0;
      eventIdQ     <= 3'd0;
      eventOneHotQ <= '0;
      dropCountQ   <= 8'd0;
    end else begin
      pendingQ     <= pendingD;
      coolQ        <= coolD;
      eventValidQ  <= eventValidD;
      eventIdQ     <= eventIdD;
      eventOneHotQ <= eventOneHotD;
      dropCountQ   <= dropCountD;
    end
  end

  assign bus.eventValid  = eventValidQ;
  assign bus.eventId     = eventIdQ;
  assign bus.eventOneHot = eventOneHotQ;
  assign bus.dropCount   = dropCountQ;

endmodule

// File: tb/tb_collision_arbiter.sv
// Randomised and directed bench for collision_arbiter. Two instances run side
// by side on identical stimulus: one with the default cooldown of 4 frames and
// one with no cooldown. A frame-level reference model predicts the outputs of
// each instance after every clock edge; a monitor compares them.
module tb_collision_arbiter;

  localparam int CD_A = 4;
  localparam int CD_B = 0;

  localparam logic [6:0] BOTTOM   = 7'b0000001;
  localparam logic [6:0] FLIPPER  = 7'b0000010;
  localparam logic [6:0] SPRING   = 7'b0000100;
  localparam logic [6:0] BUMPER   = 7'b0001000;
  localparam logic [6:0] CREDIT   = 7'b0100000;
  localparam logic [6:0] FRAMEHIT = 7'b1000000;

  typedef struct {
    bit valid;
    int id;
    int oneHot;
    int drop;
  } expT;

  logic       clk;
  logic       resetTb;
  logic       sofTb;
  logic       pauseTb;
  logic [6:0] collTb;

  int vectors;
  int miscompares;
  bit modelStarted;

  expT qA[$];
  expT qB[$];

  // Reference model state, indexed [instance][source ID 1..7].
  int mPend [2][8];
  int mCool [2][8];
  int mDrop [2];
  int mId   [2];

  collision_arbiter_if ifA ();
  collision_arbiter_if ifB ();

  assign ifA.startOfFrame = sofTb;
  assign ifA.pause        = pauseTb;
  assign {ifA.collisionBallFrame, ifA.collisionBallCredit, ifA.collisionBallObstacle,
          ifA.collisionBallBumper, ifA.collisionBallSpring, ifA.collisionBallFlipper,
          ifA.collisionBallBottom} = collTb;
  assign ifB.startOfFrame = sofTb;
  assign ifB.pause        = pauseTb;
  assign {ifB.collisionBallFrame, ifB.collisionBallCredit, ifB.collisionBallObstacle,
          ifB.collisionBallBumper, ifB.collisionBallSpring, ifB.collisionBallFlipper,
          ifB.collisionBallBottom} = collTb;

  collision_arbiter #(.COOLDOWN_FRAMES(CD_A)) dutA (.clk(clk), .reset(resetTb), .bus(ifA.slave));
  collision_arbiter #(.COOLDOWN_FRAMES(CD_B)) dutB (.clk(clk), .reset(resetTb), .bus(ifB.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock edge of frame-level behaviour for instance d.
  task automatic modelStep(input int d, input int cd, output expT e);
    int winner;
    int nElig;
    bit valid;
    winner = 0;
    nElig  = 0;
    valid  = 1'b0;
    if (resetTb) begin
      for (int s = 1; s <= 7; s++) begin
        mPend[d][s] = 0;
        mCool[d][s] = 0;
      end
      mDrop[d] = 0;
      mId[d]   = 0;
    end else if (sofTb && pauseTb) begin
      for (int s = 1; s <= 7; s++) mPend[d][s] = 0;
      mId[d] = 0;
    end else if (sofTb) begin
      for (int s = 1; s <= 7; s++) begin
        if (mPend[d][s] != 0 && mCool[d][s] == 0) begin
          nElig++;
          if (winner == 0) winner = s;
        end
      end
      if (nElig >= 2 && mDrop[d] < 255) mDrop[d]++;
      for (int s = 1; s <= 7; s++) begin
        if (winner == 1)      mCool[d][s] = 0;
        else if (s == winner) mCool[d][s] = cd;
        else if (mCool[d][s] > 0) mCool[d][s]--;
        mPend[d][s] = collTb[s-1] ? 1 : 0;
      end
      mId[d] = winner;
      valid  = (winner != 0);
    end else if (!pauseTb) begin
      for (int s = 1; s <= 7; s++) begin
        if (collTb[s-1]) mPend[d][s] = 1;
      end
    end
    e.valid  = valid;
    e.id     = mId[d];
    e.oneHot = (mId[d] == 0) ? 0 : (1 << (mId[d] - 1));
    e.drop   = mDrop[d];
  endtask

  // Predict what each instance will show after this edge and queue it.
  always @(posedge clk) begin
    expT eA;
    expT eB;
    modelStep(0, CD_A, eA);
    modelStep(1, CD_B, eB);
    qA.push_back(eA);
    qB.push_back(eB);
    modelStarted = 1'b1;
  end

  task automatic compareOne(input string name, input expT e, input logic v,
                            input logic [2:0] id, input logic [6:0] oh, input logic [7:0] dc);
    vectors++;
    if (v !== e.valid || id !== 3'(e.id) || oh !== 7'(e.oneHot) || dc !== 8'(e.drop)) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t got valid=%b id=%0d oneHot=%b drop=%0d expected valid=%b id=%0d oneHot=%b drop=%0d",
               name, $time, v, id, oh, dc, e.valid, e.id, 7'(e.oneHot), e.drop);
    end
  endtask

  // Scoreboard monitor: pops one prediction per instance each cycle.
  always @(negedge clk) begin
    if (modelStarted) begin
      if (qA.size() == 0 || qB.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL scoreboard t=%0t prediction queue empty", $time);
      end else begin
        compareOne("scoreA", qA.pop_front(), ifA.eventValid, ifA.eventId,
                   ifA.eventOneHot, ifA.dropCount);
        compareOne("scoreB", qB.pop_front(), ifB.eventValid, ifB.eventId,
                   ifB.eventOneHot, ifB.dropCount);
      end
    end
  end

  // Drive one cycle of inputs, changing them away from the rising edge.
  task automatic applyStimulus(input logic [6:0] c, input bit s, input bit p, input bit r);
    @(negedge clk);
    collTb  = c;
    sofTb   = s;
    pauseTb = p;
    resetTb = r;
  endtask

  // Directed check against hand-derived constants.
  task automatic checkOutput(input bit useB, input string name, input bit v,
                             input int id, input int drop);
    expT e;
    e.valid  = v;
    e.id     = id;
    e.oneHot = (id == 0) ? 0 : (1 << (id - 1));
    e.drop   = drop;
    if (useB) compareOne(name, e, ifB.eventValid, ifB.eventId, ifB.eventOneHot, ifB.dropCount);
    else      compareOne(name, e, ifA.eventValid, ifA.eventId, ifA.eventOneHot, ifA.dropCount);
  endtask

  // A frame with the given collisions followed by a boundary, then one idle
  // cycle so the registered grant is visible for checking.
  task automatic runFrame(input logic [6:0] c, input bit p);
    applyStimulus(c, 1'b0, p, 1'b0);
    applyStimulus(7'd0, 1'b1, p, 1'b0);
    applyStimulus(7'd0, 1'b0, p, 1'b0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    modelStarted = 1'b0;
    resetTb      = 1'b1;
    sofTb        = 1'b0;
    pauseTb      = 1'b0;
    collTb       = 7'd0;

    applyStimulus(7'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(1'b0, "resetState", 1'b0, 0, 0);

    // FLIPPER then BUMPER in one frame: FLIPPER wins, one drop.
    applyStimulus(FLIPPER, 1'b0, 1'b0, 1'b0);
    applyStimulus(BUMPER, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(1'b0, "flipperOverBumper", 1'b1, 2, 1);
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(1'b0, "validOneCycle", 1'b0, 2, 1);

    // BOTTOM beats a masked FLIPPER without a drop, and clears the cooldown.
    runFrame(BOTTOM | FLIPPER, 1'b0);
    checkOutput(1'b0, "bottomWins", 1'b1, 1, 1);
    runFrame(FLIPPER, 1'b0);
    checkOutput(1'b0, "flipperAfterBottom", 1'b1, 2, 1);

    // SPRING arriving on the boundary belongs to the following frame.
    applyStimulus(SPRING, 1'b1, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(1'b0, "springOnBoundary", 1'b0, 0, 1);
    applyStimulus(7'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(1'b0, "springNextFrame", 1'b1, 3, 1);

    // Paused frame discards collisions; unpaused frame grants normally.
    runFrame(BUMPER | CREDIT, 1'b1);
    checkOutput(1'b0, "pausedFrame", 1'b0, 0, 1);
    runFrame(BUMPER, 1'b0);
    checkOutput(1'b0, "afterPause", 1'b1, 4, 1);

    // Reset mid-frame drops the pending collision.
    applyStimulus(SPRING, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(1'b0, "resetMidFrame", 1'b0, 0, 0);

    // BUMPER every frame with a 4-frame cooldown: grant every fifth frame.
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 11; f++) begin
      runFrame(BUMPER, 1'b0);
      checkOutput(1'b0, $sformatf("bumperCooldown%0d", f), (f % 5) == 0,
                  ((f % 5) == 0) ? 4 : 0, 0);
    end

    // CREDIT and FRAME every frame with no cooldown: dropCount saturates.
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 300; f++) begin
      applyStimulus(CREDIT | FRAMEHIT, 1'b0, 1'b0, 1'b0);
      applyStimulus(7'd0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(1'b1, "dropSaturate", 1'b1, 6, 255);
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(1'b1, "resetClearsB", 1'b0, 0, 0);
    checkOutput(1'b0, "resetClearsA", 1'b0, 0, 0);

    // Random traffic, checked only by the scoreboard.
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] c;
      c = '0;
      for (int b = 0; b < 7; b++) c[b] = ($urandom_range(7) == 0);
      if ($urandom_range(40) == 0) pauseTb = ~pauseTb;
      applyStimulus(c, $urandom_range(5) == 0, pauseTb, $urandom_range(600) == 0);
    end

    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/collision_arbiter.md
COLLISION_ARBITER -- requirements
Module: collision_arbiter

Interface
REQ-001 The block SHALL have parameter COOLDOWN_FRAMES, default 4, range 0..7: frames a granted source stays masked after its grant.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port startOfFrame, input, 1, one-cycle frame-boundary pulse.
REQ-005 The block SHALL have port pause, input, 1, level signal that freezes arbitration.
REQ-006 The block SHALL have ports collisionBallBottom, collisionBallFlipper, collisionBallSpring, collisionBallBumper, collisionBallObstacle, collisionBallCredit, collisionBallFrame, each input, 1, per-pixel collision pulses.
REQ-007 The block SHALL have port eventValid, output, 1, one-cycle pulse marking a granted collision event.
REQ-008 The block SHALL have port eventId, output, 3, ID of the granted source; 0 = none.
REQ-009 The block SHALL have port eventOneHot, output, 7, one-hot form of eventId; bit (ID-1) set.
REQ-010 The block SHALL have port dropCount, output, 8, saturating count of frames in which an eligible collision lost arbitration.

Function
REQ-011 Source IDs and fixed priority SHALL be, highest first: BOTTOM=1, FLIPPER=2, SPRING=3, BUMPER=4, OBSTACLE=5, CREDIT=6, FRAME=7.
REQ-012 Each source SHALL have a sticky pending flag, set on any cycle its input is high while pause is low and startOfFrame is low.
REQ-013 On a startOfFrame cycle with pause low, the block SHALL evaluate arbitration:
- a source is eligible when its pending flag is set and its cooldown counter equals 0, using the value before this cycle's update;
- the highest-priority eligible source wins.
REQ-014 On that same cycle, the block SHALL reload each pending flag with its current-cycle input value, so a collision during startOfFrame belongs to the new frame.
REQ-015 Grant outputs SHALL be registered; for evaluation at cycle t:
- eventValid is high at t+1 for exactly one cycle, and only when there is a winner;
- eventId and eventOneHot update at t+1 and hold until the next evaluation;
- with no winner they update to 0.
REQ-016 Cooldown SHALL use one 3-bit counter per source, updated at each evaluation:
- the winner loads COOLDOWN_FRAMES;
- every other non-zero counter decrements by 1.
- Result: a grant at frame N masks that source for frames N+1..N+COOLDOWN_FRAMES.
- With COOLDOWN_FRAMES=0 there is no masking.
REQ-017 When BOTTOM wins, the block SHALL clear all seven cooldown counters to 0 and SHALL NOT load a cooldown for BOTTOM.
REQ-018 dropCount SHALL increment by 1 per evaluation with two or more eligible sources, saturating at 255.
- Sources that are pending but masked by cooldown do not count.
REQ-019 Pause behaviour:
- while pause is high, collision inputs are ignored;
- a startOfFrame cycle clears all pending flags, sets eventId and eventOneHot to 0, and produces no grant;
- cooldown counters and dropCount are held.
REQ-020 Pending flags captured before pause rose SHALL persist until the next startOfFrame and are discarded there if pause is still high.
REQ-021 Simultaneous inputs within a frame SHALL be resolved only by priority; arrival order has no effect.

Reset
REQ-022 When reset is high, on that clock edge the block SHALL clear all of the following, overriding startOfFrame and all inputs:
- all pending flags;
- all cooldown counters;
- eventValid, eventId, eventOneHot;
- dropCount.
REQ-023 Reset asserted mid-frame SHALL discard pending collisions, and the first evaluation after reset SHALL see only collisions captured after reset deasserted.

Verification
REQ-024 Scenario: in one frame, pulse FLIPPER and then BUMPER, then startOfFrame -> next cycle eventValid=1, eventId=2, eventOneHot=7'b0000010, dropCount=1.
REQ-025 Scenario: COOLDOWN_FRAMES=4, BUMPER collides every frame from frame N -> grants at N, N+5, N+10; eventId=0 on frames N+1..N+4.
REQ-026 Scenario: FLIPPER granted, then the next frame has BOTTOM and FLIPPER -> BOTTOM granted, eventId=1, dropCount unchanged because FLIPPER is masked; the frame after has FLIPPER only -> granted.
REQ-027 Scenario: pause=1 while collisions pulse, then startOfFrame -> no eventValid, eventId=0, cooldowns unchanged; pause=0, then collision and startOfFrame -> normal grant.
REQ-028 Scenario: 300 frames each with CREDIT and FRAME pending and COOLDOWN_FRAMES=0 -> dropCount saturates at 255; reset=1 for one cycle -> all outputs 0 next cycle.
REQ-029 Scenario: SPRING pulse on the same cycle as startOfFrame -> not granted at that evaluation, granted at the following one with eventId=3.
